multdiv_unit: RTL
=================

Name: multdiv_unit

Overview:
- Sequential 32-bit signed multiply/divide unit for the MIPS datapath (MULT/DIV).
- Multiply uses radix-4 Booth recoding, one partial product per cycle, so it sits beside the combinational Wallace-tree multipliers.
- Divide is non-restoring, one quotient bit per cycle.
- The decode/execute stage drives it with one-cycle start pulses and consumes a registered result and a ready strobe.

Parameters:
- WIDTH, 32, operand and result width (must be even).
- MULT_ITERS, WIDTH/2, Booth iterations.
- DIV_ITERS, WIDTH, divide iterations.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- data_operandA  in  WIDTH  multiplicand / dividend (signed).
- data_operandB  in  WIDTH  multiplier / divisor (signed).
- ctrl_MULT  in  1  start-multiply pulse.
- ctrl_DIV  in  1  start-divide pulse.
- data_result  out  WIDTH  low product word / quotient.
- data_exception  out  1  overflow or divide-by-zero flag for the last operation.
- data_resultRDY  out  1  one-cycle completion strobe.
- busy  out  1  high while an operation is in flight.

Behaviour:
Reset:
- Async assert forces state IDLE, counter 0, and all internal registers 0.
- data_result=0, data_exception=0, data_resultRDY=0, busy=0.
- Reset mid-operation aborts it. No RDY is produced for the aborted operation.
- A ctrl pulse on the first edge after reset release is accepted.

States: IDLE, MULT, DIV, DONE.
- IDLE/DONE accept a start. DONE returns to IDLE on the next edge if no start is present.

Start:
- A ctrl pulse is sampled on edge 0 (state IDLE or DONE). Operands are latched on that edge and busy goes high.
- If ctrl_MULT and ctrl_DIV are high together, MULT wins.
- Any ctrl pulse while busy=1 is ignored, and the latched operands are unaffected.

MULT:
- Edges 1..MULT_ITERS each add a Booth-selected partial product (0, ±A, ±2A) into a 2*WIDTH accumulator, then shift by 2.
- Edge MULT_ITERS+1 (edge 17): register data_result = product[31:0] and data_exception = (product[63:31] not all equal); set RDY=1; state DONE; busy=0.

DIV:
- Operands are converted to magnitudes.
- Edges 1..DIV_ITERS: non-restoring step.
- Edge DIV_ITERS+1 (edge 33): restore the sign. Quotient truncates toward zero (sign = signA xor signB). The remainder is discarded. Set RDY and DONE.
- Divisor==0: finalize on edge 1 with result=0, exception=1.
- A=0x80000000 and B=0xFFFFFFFF: finalize on edge 1 with result=0x80000000, exception=1.

Outputs:
- data_resultRDY is high for exactly one cycle: set on the finalize edge, cleared on the next edge.
- data_result and data_exception hold until the next finalize or a reset.
- A start accepted in DONE on the same edge that clears RDY is legal, giving back-to-back operations.

Arithmetic:
- All internal math is two's complement.
- The Booth accumulator is 2*WIDTH+2 bits; A is sign-extended by 2 bits for the ±2A term.

Decomposition:
- Shared include multdiv_defs.vh holds:
  - state encodings (IDLE=2'd0, MULT=2'd1, DIV=2'd2, DONE=2'd3);
  - the MULT_ITERS/DIV_ITERS defaults;
  - the INT_MIN constant.
- One sub-module, booth_recoder: combinational; takes 3 multiplier bits; outputs {neg, two, zero} selects.

Test Plan:
- Multiply small signed: A=7, B=-3 (0xFFFFFFFD), ctrl_MULT at edge 0 -> RDY only in the cycle after edge 17; result=0xFFFFFFEB; exception=0; busy high over edges 1-16.
- Multiply overflow: A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1.
- Multiply boundary: A=0x80000000, B=1 -> result=0x80000000, exception=0.
- Divide signed: A=-100, B=7 -> RDY after edge 33; result=0xFFFFFFF2 (-14); exception=0. Assert ctrl_DIV again at edge 10 with A=1, B=1 -> ignored, result unchanged.
- Divide by zero and INT_MIN/-1: A=5, B=0 -> RDY after edge 1, result=0, exception=1. Then A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1.
- Reset and back-to-back:
  - Start MULT with A=3, B=4; assert reset async at edge 8 -> all outputs 0 immediately; no RDY appears.
  - After release, ctrl_MULT with A=3, B=4 -> result=12.
  - ctrl_DIV with A=12, B=4 pulsed on the edge RDY drops -> result=3 after edge 33.

Source files
------------

// File: rtl/multdiv_unit_pkg.sv
// Shared definitions for the sequential multiply/divide unit: FSM state
// encodings, default iteration counts and the most-negative operand value.
package multdiv_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int DEF_WIDTH      = 32;
   localparam int DEF_MULT_ITERS = DEF_WIDTH / 2;
   localparam int DEF_DIV_ITERS  = DEF_WIDTH;

   localparam logic [DEF_WIDTH-1:0] INT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/multdiv_unit_booth_recoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window onto the
// partial-product selects {neg, two, zero} for 0, +-A, +-2A.
module booth_recoder
   import multdiv_unit_pkg::*;
(
   input  logic [2:0] bits,
   output logic       neg,
   output logic       two,
   output logic       zero
);

   assign neg  = bits[2] & ~(bits[1] & bits[0]);
   assign two  = (bits[2] & ~bits[1] & ~bits[0]) | (~bits[2] & bits[1] & bits[0]);
   assign zero = (bits == 3'b000) | (bits == 3'b111);

endmodule

// File: rtl/multdiv_unit.sv
// Sequential signed multiply (radix-4 Booth, two bits per cycle) and
// non-restoring divide (one quotient bit per cycle) for MULT/DIV.
module multdiv_unit
   import multdiv_unit_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int MULT_ITERS = WIDTH / 2,
   parameter int DIV_ITERS  = WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int MAX_ITERS = (MULT_ITERS > DIV_ITERS) ? MULT_ITERS : DIV_ITERS;
   localparam int CW        = $clog2(MAX_ITERS + 1);
   localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MINUS_1  = '1;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH+1:0] opnd;      // sign-extended A (mult) or |B| (div)
   logic [WIDTH+1:0] hi;        // accumulator high part / partial remainder
   logic [WIDTH-1:0] lo;        // multiplier / dividend, shifted out as result bits shift in
   logic             prev;
   logic             neg_q;
   logic             special;

   logic             start_mult, start_div, mult_last, div_last, finalize;
   logic             b_neg, b_two, b_zero;
   logic [WIDTH+1:0] pp_mag, pp, hi_sum, rem_sh, rem_nx;
   logic [WIDTH-1:0] abs_a, abs_b, q_signed;
   logic [2*WIDTH-1:0] product;

   booth_recoder u_booth (
      .bits ({lo[1:0], prev}),
      .neg  (b_neg),
      .two  (b_two),
      .zero (b_zero)
   );

   // NOTE: every signal written here gets a default first, so no path
   // through the block leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nx   = state;
      start_mult = 1'b0;
      start_div  = 1'b0;
      mult_last  = (state == ST_MULT) && (cnt == CW'(MULT_ITERS));
      div_last   = (state == ST_DIV) && (special || cnt == CW'(DIV_ITERS));
      finalize   = mult_last | div_last;
      busy       = (state == ST_MULT) || (state == ST_DIV);
      unique case (state)
         ST_IDLE, ST_DONE: begin
            start_mult = ctrl_MULT;
            start_div  = ctrl_DIV & ~ctrl_MULT;
            if (start_mult)     state_nx = ST_MULT;
            else if (start_div) state_nx = ST_DIV;
            else                state_nx = ST_IDLE;
         end
         ST_MULT: if (mult_last) state_nx = ST_DONE;
         ST_DIV:  if (div_last)  state_nx = ST_DONE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   assign pp_mag  = b_zero ? '0 : (b_two ? {opnd[WIDTH:0], 1'b0} : opnd);
   assign pp      = b_neg ? -pp_mag : pp_mag;
   assign hi_sum  = hi + pp;
   assign product = {hi[WIDTH-1:0], lo};

   assign rem_sh   = {hi[WIDTH:0], lo[WIDTH-1]};
   assign rem_nx   = hi[WIDTH+1] ? rem_sh + opnd : rem_sh - opnd;
   assign q_signed = neg_q ? -lo : lo;

   // Magnitude of the most-negative value wraps to itself, which is correct unsigned.
   assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt            <= '0;
         opnd           <= '0;
         hi             <= '0;
         lo             <= '0;
         prev           <= 1'b0;
         neg_q          <= 1'b0;
         special        <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         data_resultRDY <= finalize;
         if (start_mult) begin
            opnd    <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
            hi      <= '0;
            lo      <= data_operandB;
            prev    <= 1'b0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            special <= 1'b0;
         end else if (start_div) begin
            opnd  <= {2'b00, abs_b};
            hi    <= '0;
            prev  <= 1'b0;
            cnt   <= '0;
            neg_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            if (data_operandB == '0) begin
               special <= 1'b1;
               lo      <= '0;
            end else if (data_operandA == MIN_VAL && data_operandB == MINUS_1) begin
               special <= 1'b1;
               lo      <= MIN_VAL;
            end else begin
               special <= 1'b0;
               lo      <= abs_a;
            end
         end else if (state == ST_MULT) begin
            if (mult_last) begin
               data_result    <= product[WIDTH-1:0];
               data_exception <= ~((&product[2*WIDTH-1:WIDTH-1]) | ~(|product[2*WIDTH-1:WIDTH-1]));
            end else begin
               hi   <= {{2{hi_sum[WIDTH+1]}}, hi_sum[WIDTH+1:2]};
               lo   <= {hi_sum[1:0], lo[WIDTH-1:2]};
               prev <= lo[1];
               cnt  <= cnt + 1'b1;
            end
         end else if (state == ST_DIV) begin
            if (special) begin
               data_result    <= lo;
               data_exception <= 1'b1;
            end else if (div_last) begin
               data_result    <= q_signed;
               data_exception <= 1'b0;
            end else begin
               hi  <= rem_nx;
               lo  <= {lo[WIDTH-2:0], ~rem_nx[WIDTH+1]};
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule
